// File: rtl/window_stats.sv
// window_stats: min / max / mean / peak-to-peak over consecutive,
// non-overlapping windows of 2^k accepted samples of a signed 16-bit stream.
// Handshake: a sample is taken on every rising edge where the FSM is in
// ACCUM and din_valid=1; there is no backpressure. result_valid is a
// one-cycle strobe marking the edge on which all four result registers
// and window_count updated together.
module window_stats #(
  parameter int MAX_LOG = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [3:0]         window_log,
  input  logic signed [15:0] din,
  input  logic               din_valid,
  output logic signed [15:0] min_out,
  output logic signed [15:0] max_out,
  output logic signed [15:0] mean_out,
  output logic [16:0]        pk2pk_out,
  output logic               result_valid,
  output logic [31:0]        window_count
);

  localparam int SW = 16 + MAX_LOG;       // sum width, cannot overflow
  localparam int CW = MAX_LOG + 1;        // counter holds 2^MAX_LOG
  localparam logic [3:0] MAX_K = 4'(MAX_LOG);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                state, state_nxt;
  logic [3:0]            k_sel, k_eff, k_done;
  logic [CW-1:0]         cnt, cnt_load;
  logic                  first, done, accept, last;
  logic signed [15:0]    run_min, run_max, nxt_min, nxt_max;
  logic signed [SW-1:0]  sum, nxt_sum, din_ext;
  logic signed [16:0]    pk_diff;

  // Window exponent clamp, counter reload value and next running values
  always_comb begin
    k_sel    = (window_log > MAX_K) ? MAX_K : window_log;
    cnt_load = CW'(1) << k_sel;
    accept   = (state == ACCUM) && din_valid;
    last     = accept && (cnt == CW'(1));
    din_ext  = {{MAX_LOG{din[15]}}, din};
    if (first) begin
      nxt_min = din;
      nxt_max = din;
      nxt_sum = din_ext;
    end else begin
      nxt_min = (din < run_min) ? din : run_min;
      nxt_max = (din > run_max) ? din : run_max;
      nxt_sum = sum + din_ext;
    end
    pk_diff = {run_max[15], run_max} - {run_min[15], run_min};
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: enable low in ACCUM always returns to IDLE; a window
  // completing in that same cycle is still reported by the done flag
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = ACCUM;
      ACCUM:   if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulators: cleared in IDLE, updated per accepted sample; on the last
  // sample the window is frozen into run_* / sum and the next one restarts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_eff   <= '0;
      k_done  <= '0;
      cnt     <= '0;
      first   <= 1'b1;
      done    <= 1'b0;
      run_min <= '0;
      run_max <= '0;
      sum     <= '0;
    end else if (state == IDLE) begin
      k_eff   <= k_sel;
      cnt     <= cnt_load;
      first   <= 1'b1;
      done    <= 1'b0;
      run_min <= '0;
      run_max <= '0;
      sum     <= '0;
    end else begin
      done <= last;
      if (accept) begin
        run_min <= nxt_min;
        run_max <= nxt_max;
        sum     <= nxt_sum;
        if (last) begin
          k_done <= k_eff;
          k_eff  <= k_sel;
          cnt    <= cnt_load;
          first  <= 1'b1;
        end else begin
          cnt   <= cnt - CW'(1);
          first <= 1'b0;
        end
      end
    end
  end

  // Result registers: load the frozen window one edge after its last sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_out      <= '0;
      max_out      <= '0;
      mean_out     <= '0;
      pk2pk_out    <= '0;
      result_valid <= 1'b0;
      window_count <= '0;
    end else begin
      result_valid <= done;
      if (done) begin
        min_out      <= run_min;
        max_out      <= run_max;
        mean_out     <= 16'(sum >>> k_done);
        pk2pk_out    <= pk_diff;
        window_count <= window_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_window_stats.sv
// Bench for window_stats: a window model pushes expected results to exp_q as
// samples are driven; results seen on result_valid go to got_q and each
// scenario task compares the two queues plus its own timing constraints.
module tb_window_stats;

  typedef struct packed {
    logic signed [15:0] mn;
    logic signed [15:0] mx;
    logic signed [15:0] mean;
    logic [16:0]        pk;
    logic [31:0]        cnt;
  } res_t;

  logic               clk = 1'b0;
  logic               reset, enable, din_valid;
  logic [3:0]         window_log;
  logic signed [15:0] din;
  logic signed [15:0] min_out, max_out, mean_out;
  logic [16:0]        pk2pk_out;
  logic               result_valid;
  logic [31:0]        window_count;

  window_stats dut (
    .clk(clk), .reset(reset), .enable(enable), .window_log(window_log),
    .din(din), .din_valid(din_valid), .min_out(min_out), .max_out(max_out),
    .mean_out(mean_out), .pk2pk_out(pk2pk_out), .result_valid(result_valid),
    .window_count(window_count)
  );

  // clock
  always #5 clk = ~clk;

  res_t exp_q[$];
  res_t got_q[$];
  int   got_cyc[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // window model
  bit          mdl_on = 1'b0;
  int          mdl_n, mdl_k, mdl_min, mdl_max;
  longint      mdl_sum;
  int unsigned mdl_wcount = 0;
  res_t        mdl_last = '0;

  function automatic int clamp_k(input logic [3:0] w);
    return (w > 4'd12) ? 12 : int'(w);
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("min=%0d max=%0d mean=%0d pk2pk=%0d count=%0d",
                     r.mn, r.mx, r.mean, r.pk, r.cnt);
  endfunction

  task automatic model_start();
    mdl_k = clamp_k(window_log);
    mdl_n = 0;
  endtask

  task automatic model_sample(input int v);
    longint d, q;
    res_t   e;
    if (mdl_n == 0) begin
      mdl_min = v; mdl_max = v; mdl_sum = v;
    end else begin
      if (v < mdl_min) mdl_min = v;
      if (v > mdl_max) mdl_max = v;
      mdl_sum += v;
    end
    mdl_n++;
    if (mdl_n == (1 << mdl_k)) begin
      d = longint'(1) << mdl_k;
      q = mdl_sum / d;
      if (mdl_sum < 0 && (mdl_sum % d) != 0) q = q - 1;
      mdl_wcount++;
      e.mn   = 16'(mdl_min);
      e.mx   = 16'(mdl_max);
      e.mean = 16'(q);
      e.pk   = 17'(mdl_max - mdl_min);
      e.cnt  = mdl_wcount;
      exp_q.push_back(e);
      mdl_last = e;
      mdl_n = 0;
      mdl_k = clamp_k(window_log);
    end
  endtask

  // driver: one clock per call, capture any result strobe
  task automatic step(input logic v, input logic signed [15:0] d);
    res_t g;
    din_valid = v;
    din = d;
    if (v && mdl_on) model_sample(int'(d));
    @(posedge clk);
    #1;
    cyc++;
    if (result_valid) begin
      g.mn = min_out; g.mx = max_out; g.mean = mean_out;
      g.pk = pk2pk_out; g.cnt = window_count;
      got_q.push_back(g);
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic restart(input logic [3:0] k);
    mdl_on = 1'b0;
    enable = 1'b0;
    step(1'b0, '0);
    step(1'b0, '0);
    window_log = k;
    enable = 1'b1;
    step(1'b0, '0);   // enable-rise cycle: no sample accepted
    model_start();
    mdl_on = 1'b1;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  function automatic logic signed [15:0] rnd();
    return 16'($urandom_range(0, 65535));
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; window_log = 4'd0; din = '0; din_valid = 1'b0;
    step(1'b0, '0); step(1'b0, '0); step(1'b0, '0);
    n_checks++; if (min_out !== 16'sd0) begin n_fail++; $display("FAIL reset_min: got %0d need 0", min_out); end
    n_checks++; if (max_out !== 16'sd0) begin n_fail++; $display("FAIL reset_max: got %0d need 0", max_out); end
    n_checks++; if (mean_out !== 16'sd0) begin n_fail++; $display("FAIL reset_mean: got %0d need 0", mean_out); end
    n_checks++; if (pk2pk_out !== 17'd0) begin n_fail++; $display("FAIL reset_pk2pk: got %0d need 0", pk2pk_out); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b need 0", result_valid); end
    n_checks++; if (window_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d need 0", window_count); end
    reset = 1'b0;
    step(1'b0, '0);
  endtask

  task automatic test_ramp();
    res_t e, g;
    restart(4'd2);
    step(1'b1, -16'sd2); step(1'b1, -16'sd1); step(1'b1, 16'sd0); step(1'b1, 16'sd5);
    step(1'b0, '0); step(1'b0, '0); step(1'b0, '0);
    n_checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL ramp_pulses: got %0d results need 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL ramp_result: got %s need %s", fmt(g), fmt(e)); end
      n_checks++;
      if (g.mn !== -16'sd2 || g.mx !== 16'sd5 || g.mean !== 16'sd0 || g.pk !== 17'd7 || g.cnt !== 32'd1) begin
        n_fail++; $display("FAIL ramp_const: got %s need min=-2 max=5 mean=0 pk2pk=7 count=1", fmt(g));
      end
    end
  endtask

  task automatic test_extremes();
    res_t e, g;
    restart(4'd1);
    step(1'b1, -16'sd32768); step(1'b1, 16'sd32767);
    step(1'b0, '0); step(1'b0, '0);
    n_checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL extremes_pulses: got %0d results need 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL extremes_result: got %s need %s", fmt(g), fmt(e)); end
      n_checks++;
      if (g.mn !== -16'sd32768 || g.mx !== 16'sd32767 || g.mean !== -16'sd1 || g.pk !== 17'd65535) begin
        n_fail++; $display("FAIL extremes_const: got %s need min=-32768 max=32767 mean=-1 pk2pk=65535", fmt(g));
      end
    end
  endtask

  task automatic test_gaps_clamp();
    res_t e, g;
    int s1;
    restart(4'd15);
    for (int i = 0; i < 8191; i++) begin
      step((i % 2) == 0, rnd());
      if (i == 0) s1 = cyc;
    end
    for (int i = 0; i < 4096; i++) step(1'b1, rnd());
    step(1'b0, '0);
    n_checks++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      n_fail++; $display("FAIL gaps_pulses: got %0d results need 2", got_q.size());
    end else begin
      n_checks++;
      if (got_cyc[0] !== s1 + 8191) begin n_fail++; $display("FAIL gaps_first_time: got cycle %0d need %0d", got_cyc[0], s1 + 8191); end
      n_checks++;
      if (got_cyc[1] - got_cyc[0] !== 4096) begin n_fail++; $display("FAIL gaps_second_time: got spacing %0d need 4096", got_cyc[1] - got_cyc[0]); end
      for (int i = 0; i < 2; i++) begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL gaps_result%0d: got %s need %s", i, fmt(g), fmt(e)); end
      end
    end
  endtask

  task automatic test_abort_reconfig();
    res_t e, g;
    logic signed [15:0] v;
    logic signed [15:0] sent[$];
    int n;
    restart(4'd3);
    for (int i = 0; i < 5; i++) step(1'b1, rnd());
    mdl_on = 1'b0;
    enable = 1'b0;
    step(1'b0, '0); step(1'b1, rnd()); step(1'b0, '0);
    n_checks++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL abort_no_result: got %0d results need 0", got_q.size()); end
    n_checks++;
    if (min_out !== mdl_last.mn || max_out !== mdl_last.mx || mean_out !== mdl_last.mean ||
        pk2pk_out !== mdl_last.pk || window_count !== mdl_last.cnt) begin
      n_fail++; $display("FAIL abort_hold: got min=%0d max=%0d mean=%0d pk2pk=%0d count=%0d need %s",
                         min_out, max_out, mean_out, pk2pk_out, window_count, fmt(mdl_last));
    end
    window_log = 4'd0;
    enable = 1'b1;
    step(1'b0, '0);
    model_start();
    mdl_on = 1'b1;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      v = rnd();
      if (i == 3 || i == 7) step(1'b0, v);
      else begin step(1'b1, v); sent.push_back(v); end
    end
    step(1'b0, '0);
    n = exp_q.size();
    n_checks++;
    if (got_q.size() != 8 || n != 8) begin
      n_fail++; $display("FAIL k0_pulses: got %0d results need 8", got_q.size());
    end else begin
      n_checks++;
      if (got_cyc[1] - got_cyc[0] !== 1) begin n_fail++; $display("FAIL k0_back_to_back: got spacing %0d need 1", got_cyc[1] - got_cyc[0]); end
      for (int i = 0; i < 8; i++) begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        n_checks++;
        if (g !== e || g.mean !== sent[i] || g.pk !== 17'd0) begin
          n_fail++; $display("FAIL k0_result%0d: got %s need %s", i, fmt(g), fmt(e));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e, g;
    int s4;
    restart(4'd2);
    step(1'b1, rnd()); step(1'b1, rnd());
    window_log = 4'd3;
    step(1'b1, rnd()); step(1'b1, rnd());
    s4 = cyc;
    for (int i = 0; i < 8; i++) step(1'b1, rnd());
    step(1'b0, '0);
    n_checks++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d results need 2", got_q.size());
    end else begin
      n_checks++;
      if (got_cyc[0] !== s4 + 1) begin n_fail++; $display("FAIL b2b_first_time: got cycle %0d need %0d", got_cyc[0], s4 + 1); end
      n_checks++;
      if (got_cyc[1] - got_cyc[0] !== 8) begin n_fail++; $display("FAIL b2b_second_len: got spacing %0d need 8", got_cyc[1] - got_cyc[0]); end
      for (int i = 0; i < 2; i++) begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL b2b_result%0d: got %s need %s", i, fmt(g), fmt(e)); end
      end
    end
  endtask

  task automatic test_enable_drop_on_last();
    res_t e, g;
    restart(4'd1);
    step(1'b1, rnd());
    enable = 1'b0;
    step(1'b1, rnd());   // completing sample, still counted
    mdl_on = 1'b0;
    step(1'b0, '0); step(1'b1, rnd()); step(1'b1, rnd()); step(1'b0, '0);
    n_checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL droplast_pulses: got %0d results need 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL droplast_result: got %s need %s", fmt(g), fmt(e)); end
    end
  endtask

  task automatic test_reset_mid();
    res_t e, g;
    restart(4'd2);
    step(1'b1, rnd()); step(1'b1, rnd());
    mdl_on = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (min_out !== 16'sd0 || max_out !== 16'sd0 || mean_out !== 16'sd0 || pk2pk_out !== 17'd0 ||
        result_valid !== 1'b0 || window_count !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: got min=%0d max=%0d mean=%0d pk2pk=%0d valid=%b count=%0d need all 0",
                         min_out, max_out, mean_out, pk2pk_out, result_valid, window_count);
    end
    step(1'b1, rnd()); step(1'b1, rnd()); step(1'b1, rnd());
    n_checks++;
    if (window_count !== 32'd0 || result_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: got valid=%b count=%0d need 0 0", result_valid, window_count);
    end
    reset = 1'b0;
    mdl_wcount = 0;
    restart(4'd0);
    step(1'b1, 16'sd123);
    step(1'b0, '0);
    n_checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL post_reset_pulses: got %0d results need 1", got_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e || g.cnt !== 32'd1) begin n_fail++; $display("FAIL post_reset_result: got %s need %s", fmt(g), fmt(e)); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_extremes();
    test_gaps_clamp();
    test_abort_reconfig();
    test_back_to_back();
    test_enable_drop_on_last();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/window_stats.md
# window_stats

Streaming window-statistics stage placed directly downstream of the moving-average/moving-median filters in the custom-instrument top level. It consumes the filtered 16-bit signed sample stream and, over consecutive non-overlapping windows of 2^k accepted samples, produces minimum, maximum, mean and peak-to-peak. Results are registered once per window with a one-cycle valid strobe, so they can drive status registers or a slow output channel.

## Interface

Parameters:
- MAX_LOG, default 12: largest supported window exponent; the window is at most 2^MAX_LOG samples.

Ports:
- clk, input, 1: sole clock; all logic is rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: run/abort control (e.g. a control-register bit).
- window_log, input, 4: window exponent k; values above MAX_LOG are clamped to MAX_LOG.
- din, input, 16 signed: filtered sample (moving-average output).
- din_valid, input, 1: sample-accept qualifier; tie high for every-cycle streams.
- min_out, output, 16 signed: minimum of the last completed window.
- max_out, output, 16 signed: maximum of the last completed window.
- mean_out, output, 16 signed: floor(sum / 2^k) of the last completed window.
- pk2pk_out, output, 17 unsigned: max − min of the last completed window.
- result_valid, output, 1: one-cycle pulse when all four results update.
- window_count, output, 32: number of completed windows since reset; wraps modulo 2^32.

## Operation

- FSM has two states, IDLE and ACCUM. Reset enters IDLE.
- IDLE:
  - Accumulators are held cleared.
  - When enable=1, latch k_eff = min(window_log, MAX_LOG), load sample counter with 2^k_eff, and go to ACCUM on the next cycle.
  - Samples are not accepted in the cycle enable first rises.
- ACCUM: each cycle with din_valid=1 accepts din:
  - First sample of a window: running_min = running_max = din, sum = sign-extended din.
  - Later samples: running_min = min(running_min, din), running_max = max(running_max, din), sum += din.
  - Counter decrements per accepted sample.
- Window completion, when the accepted sample makes the counter reach zero:
  - Registered results are computed from the final values, including that sample.
  - min_out and max_out take the running values.
  - mean_out = sum >>> k_eff (arithmetic shift, floor toward −∞).
  - pk2pk_out = max − min, evaluated as 17-bit signed and always ≥ 0.
  - result_valid pulses for one cycle; window_count increments.
- Next window starts immediately, back-to-back, with no dead cycle:
  - window_log is re-sampled at each window start.
  - A change mid-window takes effect only on the next window.
- Sum width is 16 + MAX_LOG signed bits (28 by default). No overflow is possible.
- k_eff = 0 gives a one-sample window: every accepted sample produces a result, mean = min = max = din, pk2pk = 0.
- din_valid=0 cycles are ignored; window length counts accepted samples, not cycles.
- enable deasserted in ACCUM:
  - The partial window is discarded; return to IDLE next cycle.
  - Outputs and window_count hold their last completed values; no result_valid.
- enable deasserted in the same cycle as the completing sample: that window still completes and is reported, then the FSM goes to IDLE.
- Reset (asynchronous, any time, including mid-window):
  - All outputs go to 0 and result_valid to 0; window_count = 0; FSM to IDLE.

## Timing

- Latency: result registers and result_valid assert on the clock edge one cycle after the edge that accepts the final sample of the window.
- Throughput: one sample per clock; a result every 2^k_eff accepted samples.
- Output stability: min_out, max_out, mean_out and pk2pk_out change only in the cycle result_valid=1 and are stable otherwise.
- result_valid is never high for two consecutive cycles unless k_eff = 0 and din_valid is continuously high.
- enable rise to first accepted sample: 1 cycle (the IDLE→ACCUM transition).

## Test plan

- Reset values: assert reset for 3 cycles during activity → all outputs are 0, result_valid is 0 and window_count is 0, asynchronously and without waiting for a clock edge.
- Ramp:
  - Stimulus: k=2, din = −2, −1, 0, 5 with din_valid high.
  - Required: one cycle after the 4th sample, min=−2, max=5, mean=0 (sum 2 >>> 2), pk2pk=7, result_valid is a single pulse, window_count=1.
- Extremes and floor:
  - Stimulus: k=1, din = −32768, 32767.
  - Required: min=−32768, max=32767, pk2pk=65535, mean=−1 (sum −1 >>> 1).
- Gaps and clamping:
  - Stimulus: window_log=15 (clamped to 12), din_valid toggled every other cycle.
  - Required: result_valid after exactly 4096 accepted samples (8191 cycles), and 4096 cycles after that for the next result.
- Abort and reconfigure:
  - Stimulus: k=3; drop enable after 5 samples; change window_log to 0; re-enable.
  - Required: no result for the aborted window and previous outputs held. After re-enable, each accepted sample gives result_valid with mean=min=max=din.
- Mid-stream window change and back-to-back windows:
  - Stimulus: change window_log from 2 to 3 during a window.
  - Required: the current window still completes after 4 samples, the following window takes 8 samples, and there is no gap between windows.
